cla_adder_pipe: RTL and testbench

//  - Parametrised, pipelined carry-look-ahead adder/subtractor. Successor to the team's 4-bit CLA.
//  - Operands are split into SEGS segments; each pipeline stage resolves one segment with

---
 rtl/cla_pkg.sv | 19 +
 rtl/cla_block.sv | 48 ++++
 rtl/cla_adder_pipe.sv | 124 ++++++++++++
 tb/tb_cla_adder_pipe.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared types and configuration helpers for the pipelined carry-look-ahead adder.
// Pure declarations: no logic, no latency, no flow control.
package cla_pkg;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  function automatic int seg_width(input int width, input int segs);
    return width / segs;
  endfunction

  // Every stage must hold a whole number of look-ahead groups.
  function automatic bit cfg_ok(input int width, input int block, input int segs);
    return (segs >= 1) && (block >= 1) && ((width % (segs * block)) == 0);
  endfunction

endpackage

// File: rtl/cla_block.sv
// Combinational BLOCK-bit carry-look-ahead group: sum bits plus group generate/propagate.
// Zero latency, no flow control; the enclosing stage register owns the handshake.
module cla_block #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             ci,
  output logic [BLOCK-1:0] s,
  output logic             g,
  output logic             p
);

  logic [BLOCK-1:0] gi;
  logic [BLOCK-1:0] pi;
  logic [BLOCK-1:0] c;
  logic             t;

  assign gi = a & b;
  assign pi = a ^ b;

  // Each carry is a flat sum-of-products over the group; no bit waits on its neighbour.
  always_comb begin
    c    = '0;
    c[0] = ci;
    g    = 1'b0;
    t    = 1'b0;
    for (int i = 1; i < BLOCK; i++) begin
      t = ci;
      for (int j = 0; j < i; j++) t = t & pi[j];
      c[i] = t;
      for (int j = 0; j < i; j++) begin
        t = gi[j];
        for (int m = j + 1; m < i; m++) t = t & pi[m];
        c[i] = c[i] | t;
      end
    end
    for (int j = 0; j < BLOCK; j++) begin
      t = gi[j];
      for (int m = j + 1; m < BLOCK; m++) t = t & pi[m];
      g = g | t;
    end
  end

  assign p = &pi;
  assign s = pi ^ c;

endmodule

// File: rtl/cla_adder_pipe.sv
// Pipelined CLA add/sub, one segment per stage: SEGS cycles latency, one result per cycle.
// A held output (out_valid & ~out_ready) freezes every stage and drops in_ready.
module cla_adder_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BLOCK = 4,
  parameter int SEGS  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int SW = seg_width(WIDTH, SEGS);
  localparam int NB = SW / BLOCK;

  if (!cfg_ok(WIDTH, BLOCK, SEGS)) begin : g_cfg_err
    $error("cla_adder_pipe: WIDTH must be a multiple of SEGS*BLOCK");
  end

  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < SEGS; k++) begin : g_stg
    localparam int HW = WIDTH - k * SW;  // operand bits not yet summed
    localparam int LW = (k + 1) * SW;    // sum bits completed after this stage

    logic [HW-1:0] ai;
    logic [HW-1:0] bi;
    logic          ci;
    logic          vi;
    logic [SW-1:0] ssum;
    logic [NB:0]   gc;
    gp_t           gp [NB];
    logic [LW-1:0] s_nxt;
    logic [LW-1:0] s_q;
    logic          c_q;
    logic          v_q;

    if (k == 0) begin : g_src
      assign ai    = a;
      assign bi    = b ^ {WIDTH{sub}};
      assign ci    = sub | cin;
      assign vi    = in_valid;
      assign s_nxt = ssum;
    end else begin : g_src
      assign ai    = g_stg[k-1].g_skew.a_q;
      assign bi    = g_stg[k-1].g_skew.b_q;
      assign ci    = g_stg[k-1].c_q;
      assign vi    = g_stg[k-1].v_q;
      assign s_nxt = {ssum, g_stg[k-1].s_q};
    end

    assign gc[0] = ci;
    for (genvar j = 0; j < NB; j++) begin : g_grp
      cla_block #(.BLOCK(BLOCK)) u_blk (
        .a  (ai[j*BLOCK +: BLOCK]),
        .b  (bi[j*BLOCK +: BLOCK]),
        .ci (gc[j]),
        .s  (ssum[j*BLOCK +: BLOCK]),
        .g  (gp[j].g),
        .p  (gp[j].p)
      );
      assign gc[j+1] = gp[j].g | (gp[j].p & gc[j]);
    end

    // Data only loads on a valid transfer, so a bubble leaves the last result visible.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        s_q <= '0;
        c_q <= 1'b0;
      end else if (adv) begin
        v_q <= vi;
        if (vi) begin
          s_q <= s_nxt;
          c_q <= gc[NB];
        end
      end
    end

    if (k < SEGS - 1) begin : g_skew
      logic [HW-SW-1:0] a_q;
      logic [HW-SW-1:0] b_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv && vi) begin
          a_q <= ai[HW-1:SW];
          b_q <= bi[HW-1:SW];
        end
      end
    end else begin : g_last
      logic ovf_q;
      // Carry into the MSB is recovered as s ^ p of that bit.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (adv && vi) begin
          ovf_q <= ssum[SW-1] ^ ai[SW-1] ^ bi[SW-1] ^ gc[NB];
        end
      end
    end
  end

  assign out_valid = g_stg[SEGS-1].v_q;
  assign sum       = g_stg[SEGS-1].s_q;
  assign carry     = g_stg[SEGS-1].c_q;
  assign overflow  = g_stg[SEGS-1].g_last.ovf_q;

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Bench for cla_adder_pipe: directed literal vectors, back-to-back and backpressured random
// traffic against an arithmetic reference queue, and a mid-flight reset.
module tb_cla_adder_pipe;

  localparam int W  = 32;
  localparam int BL = 4;
  localparam int SG = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         carry;
  logic         overflow;

  cla_adder_pipe #(.WIDTH(W), .BLOCK(BL), .SEGS(SG)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry     (carry),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    int           t;
  } exp_t;

  exp_t   q[$];
  int     errors = 0;
  int     checks = 0;
  int     cyc = 0;
  bit     chk_lat = 1'b0;
  bit     stall = 1'b0;
  logic [W-1:0] hs;
  logic         hc;
  logic         ho;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: plain unsigned/signed arithmetic on the operands.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic sb, input int t);
    exp_t   e;
    longint sx, sy, r, ux, uy, lim;
    sx  = $signed(x);
    sy  = $signed(y);
    ux  = x;
    uy  = y;
    lim = 64'sd2147483648;
    if (sb) begin
      r   = sx - sy;
      e.s = x - y;
      e.c = (x >= y);
    end else begin
      r   = sx + sy + ci;
      e.s = x + y + ci;
      e.c = ((ux + uy + ci) >> W) != 0;
    end
    e.o = (r >= lim) || (r < -lim);
    e.t = t;
    return e;
  endfunction

  // Single compare process, sampled mid-cycle after inputs have settled.
  always @(negedge clk) begin
    exp_t e;
    #3;
    cyc++;
    if (!rst_n) begin
      q.delete();
      stall = 1'b0;
    end else begin
      check("in_ready", in_ready, !(out_valid && !out_ready));
      if (stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_sum", sum, hs);
        check("stall_carry", carry, hc);
        check("stall_ovf", overflow, ho);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got sum %0h expected no output", sum);
        end else begin
          e = q.pop_front();
          check("sum", sum, e.s);
          check("carry", carry, e.c);
          check("overflow", overflow, e.o);
          if (chk_lat) check("latency", cyc - e.t, SG);
        end
      end
      stall = out_valid && !out_ready;
      hs = sum;
      hc = carry;
      ho = overflow;
      if (in_valid && in_ready) q.push_back(model(a, b, cin, sub, cyc));
    end
  end

  task automatic run_dir(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                         input logic sb, input logic [W-1:0] es, input logic ec,
                         input logic eo);
    int  k;
    bit  found;
    @(negedge clk);
    a = x; b = y; cin = ci; sub = sb; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    k = 1;
    found = 1'b0;
    while (!found && k < 20) begin
      #4;
      if (out_valid) found = 1'b1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL dir_timeout: got no out_valid expected one for a=%0h b=%0h", x, y);
    end else begin
      check("dir_latency", k, SG);
      check("dir_sum", sum, es);
      check("dir_carry", carry, ec);
      check("dir_ovf", overflow, eo);
    end
  endtask

  task automatic drain();
    int k;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    k = 0;
    while (q.size() > 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    check("drain_empty", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    repeat (3) @(negedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_carry", carry, 0);
    check("rst_ovf", overflow, 0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);

    chk_lat = 1'b1;
    run_dir(32'hFFFF_FFFF, 32'h1,         1'b0, 1'b0, 32'h0,         1'b1, 1'b0);
    run_dir(32'h7FFF_FFFF, 32'h1,         1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_dir(32'h5,         32'h7,         1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_dir(32'h7,         32'h5,         1'b0, 1'b1, 32'h2,         1'b1, 1'b0);
    run_dir(32'h7,         32'h5,         1'b1, 1'b1, 32'h2,         1'b1, 1'b0);
    run_dir(32'h8000_0000, 32'h1,         1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    run_dir(32'h0F0F_0F0F, 32'h10F0_F0F0, 1'b1, 1'b0, 32'h2000_0000, 1'b0, 1'b0);
    run_dir(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1);
    run_dir(32'h0,         32'h0,         1'b0, 1'b1, 32'h0,         1'b1, 1'b0);

    // Back-to-back, no backpressure.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a   = (i % 8 == 0) ? 32'hFFFF_FFFF : $urandom;
      b   = (i % 8 == 1) ? 32'h8000_0000 : $urandom;
      cin = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
    end
    drain();

    // Random valid and ready.
    chk_lat = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!(in_valid && !in_ready)) begin
        a   = $urandom;
        b   = $urandom;
        cin = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
      end
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
    end
    drain();

    // Reset with three operations in flight.
    run_dir(32'h7, 32'h5, 1'b0, 1'b1, 32'h2, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = 32'h1000 + i;
      b = 32'h2000;
      cin = 1'b0;
      sub = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_sum", sum, 0);
    check("midrst_carry", carry, 0);
    check("midrst_ovf", overflow, 0);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      #4;
      if (out_valid) seen++;
    end
    check("stale_after_reset", seen, 0);

    chk_lat = 1'b1;
    run_dir(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
